// File: rtl/dmem_unit_if.sv
// Request/response bundle between the EX/MEM register and dmem_unit.
// The master drives a load/store request; the slave returns load data and debug state.
interface dmem_unit_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [DM_ADDRESS-1:0] addr;
  logic [DATA_W-1:0]     wr_data;
  logic [2:0]            funct3;
  logic [DATA_W-1:0]     rd_data;
  logic [DATA_W-1:0]     mmio_out;
  logic [15:0]           store_count;
  logic                  fault;
  logic [DM_ADDRESS-1:0] fault_addr;

  modport master (
    output MemRead, MemWrite, addr, wr_data, funct3,
    input  rd_data, mmio_out, store_count, fault, fault_addr
  );

  modport slave (
    input  MemRead, MemWrite, addr, wr_data, funct3,
    output rd_data, mmio_out, store_count, fault, fault_addr
  );
endinterface

// File: rtl/dmem_unit.sv
// Byte-addressed RV32I data memory with one MMIO output word, a store counter and a fault record.
// Optional: define DMEM_MISALIGN_TRAP_EN to trap misaligned/invalid accesses instead of forcing alignment.

module dmem_unit_chk (
  input logic        clk,
  input logic        reset,
  input logic [15:0] store_count,
  input logic        fault
);
  // Counter only holds or steps by one outside reset; it may wrap.
  a_count_step: assert property (@(posedge clk)
    $past(reset) |-> ((store_count == $past(store_count)) ||
                      (store_count == ($past(store_count) + 16'd1))));

  // Once raised, fault stays up until the next reset.
  a_fault_sticky: assert property (@(posedge clk)
    ($past(reset) && $past(fault)) |-> fault);
endmodule

module dmem_unit #(
  parameter int                    DM_ADDRESS = 9,
  parameter int                    DATA_W     = 32,
  parameter logic [DM_ADDRESS-1:0] MMIO_ADDR  = 9'h1FC
) (
  input logic         clk,
  input logic         reset,
  dmem_unit_if.slave  bus
);

  localparam int WORDS = 1 << (DM_ADDRESS - 2);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } size_e;

  function automatic size_e decode_size(input logic [2:0] f);
    size_e sz;
    case (f)
      3'b000, 3'b100: sz = SZ_BYTE;
      3'b001, 3'b101: sz = SZ_HALF;
      3'b010:         sz = SZ_WORD;
      default:        sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
    logic [3:0] m;
    case (sz)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = 4'b0011 << off;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input size_e sz,
                                               input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (sz)
      SZ_BYTE: res = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      SZ_WORD: res = sh;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  logic [DATA_W-1:0]     mem [0:WORDS-1];
  logic [DATA_W-1:0]     mmio_r;
  logic [15:0]           count_r;

  size_e                 size_s;
  logic                  valid_s;
  logic [1:0]            off_s;
  logic [DM_ADDRESS-3:0] widx_s;
  logic                  is_mmio_s;
  logic                  access_ok_s;
  logic                  store_s;
  logic [3:0]            be_s;
  logic [DATA_W-1:0]     wdata_s;
  logic [DATA_W-1:0]     src_s;
  logic [DATA_W-1:0]     rd_data_s;

  // Decode size, effective lane offset and target (RAM word or MMIO register).
  always_comb begin
    size_s    = decode_size(bus.funct3);
    valid_s   = (size_s != SZ_NONE);
    widx_s    = bus.addr[DM_ADDRESS-1:2];
    is_mmio_s = (widx_s == MMIO_ADDR[DM_ADDRESS-1:2]);
    case (size_s)
      SZ_BYTE: off_s = bus.addr[1:0];
      SZ_HALF: off_s = {bus.addr[1], 1'b0};
      SZ_WORD: off_s = 2'b00;
      default: off_s = 2'b00;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign_s;
  logic fault_set_s;
  logic fault_r;
  logic [DM_ADDRESS-1:0] fault_addr_r;

  // A misaligned access is rejected rather than silently realigned.
  always_comb begin
    case (size_s)
      SZ_HALF: misalign_s = bus.addr[0];
      SZ_WORD: misalign_s = (bus.addr[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
    access_ok_s = valid_s && !misalign_s;
    fault_set_s = (bus.MemRead || bus.MemWrite) && !access_ok_s;
  end

  // Sticky fault flag; the address is captured only for the first fault since reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fault_r      <= 1'b0;
      fault_addr_r <= {DM_ADDRESS{1'b0}};
    end else if (fault_set_s && !fault_r) begin
      fault_r      <= 1'b1;
      fault_addr_r <= bus.addr;
    end else begin
      fault_r      <= fault_r;
      fault_addr_r <= fault_addr_r;
    end
  end

  assign bus.fault      = fault_r;
  assign bus.fault_addr = fault_addr_r;
`else
  // Low address bits below the access size are already dropped by off_s.
  always_comb begin
    access_ok_s = valid_s;
  end

  assign bus.fault      = 1'b0;
  assign bus.fault_addr = {DM_ADDRESS{1'b0}};
`endif

  // Store enables and lane-replicated write data; a store is dropped while in reset.
  always_comb begin
    store_s = reset && bus.MemWrite && access_ok_s;
    be_s    = lane_mask(size_s, off_s);
    case (size_s)
      SZ_BYTE: wdata_s = {4{bus.wr_data[7:0]}};
      SZ_HALF: wdata_s = {2{bus.wr_data[15:0]}};
      SZ_WORD: wdata_s = bus.wr_data;
      default: wdata_s = {DATA_W{1'b0}};
    endcase
  end

  // Combinational load path; a simultaneous store wins and the load returns zero.
  always_comb begin
    src_s = is_mmio_s ? mmio_r : mem[widx_s];
    if (reset && bus.MemRead && !bus.MemWrite && access_ok_s) begin
      rd_data_s = load_extract(src_s, size_s, off_s, bus.funct3[2]);
    end else begin
      rd_data_s = {DATA_W{1'b0}};
    end
  end

  // RAM byte-lane writes; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (store_s && !is_mmio_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem[widx_s][8*b +: 8] <= wdata_s[8*b +: 8];
        end
      end
    end
  end

  // MMIO register and committed-store counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mmio_r  <= {DATA_W{1'b0}};
      count_r <= 16'd0;
    end else if (store_s) begin
      count_r <= count_r + 16'd1;
      if (is_mmio_s) begin
        for (int b = 0; b < 4; b++) begin
          if (be_s[b]) begin
            mmio_r[8*b +: 8] <= wdata_s[8*b +: 8];
          end
        end
      end
    end else begin
      mmio_r  <= mmio_r;
      count_r <= count_r;
    end
  end

  assign bus.rd_data     = rd_data_s;
  assign bus.mmio_out    = mmio_r;
  assign bus.store_count = count_r;

  dmem_unit_chk u_chk (
    .clk         (clk),
    .reset       (reset),
    .store_count (bus.store_count),
    .fault       (bus.fault)
  );

endmodule
